serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
Sequential restoring divider: unsigned dividend / divisor, one quotient bit per clock, MSB first. Inverse companion to the team's serial shift-and-add multiplier. Shares the same start-pulse launch style and adds busy/done handshake and divide-by-zero reporting. Used wherever area matters more than divide latency.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  launch request, sampled on clk rising edge
dividend  input  WIDTH  unsigned dividend, captured when start is accepted
divisor  input  WIDTH  unsigned divisor, captured when start is accepted
quotient  output  WIDTH  registered quotient, valid while done=1, held afterwards
remainder  output  WIDTH  registered remainder, valid while done=1, held afterwards
busy  output  1  high while an iteration sequence is in progress
done  output  1  single-cycle completion pulse
div_by_zero  output  1  set with done when captured divisor==0, held until next completion

Behaviour:
- Reset (rst_n=0, async): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; internal counter and working registers=0. Reset mid-operation aborts the divide. No done is produced for the aborted divide.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept: start=1 at an edge while state is IDLE or DONE captures the operands. start while in RUN is ignored, with no effect on the operation in flight.
- Accept with divisor!=0:
  - Load working dividend shift register.
  - Load partial remainder (WIDTH+1 bits) = 0.
  - Load count = WIDTH.
  - Next state = RUN.
- RUN iteration (each edge):
  - Form pr' = {pr[WIDTH-1:0], dividend_sr MSB} and shift dividend_sr left.
  - Compute t = pr' - {1'b0, divisor}.
  - If t is non-negative (MSB=0): pr = t and the quotient bit = 1. Otherwise pr = pr' and the quotient bit = 0.
  - Quotient bits shift in LSB-first into the working quotient, so the first bit ends up at the MSB.
  - count decrements by 1.
- Completion: the edge that performs the iteration with count==1 also:
  - writes quotient and remainder (pr[WIDTH-1:0]) outputs;
  - clears div_by_zero;
  - sets next state = DONE.
- Latency: start accepted at edge k leads to done=1 in the cycle following edge k+WIDTH, so WIDTH cycles start-to-done. busy=1 in the cycles following edges k .. k+WIDTH-1.
- Accept with divisor==0:
  - Next state = DONE directly (done=1 in the cycle after the accept edge).
  - quotient = all ones.
  - remainder = captured dividend.
  - div_by_zero = 1.
- DONE leaves to IDLE on the next edge unless start=1, which starts a new accept (back-to-back). Output registers hold their values until the next completion.
- dividend=0 with divisor!=0: the full WIDTH-cycle sequence still runs and produces quotient=0, remainder=0.
- Invariant: for divisor!=0, dividend == quotient*divisor + remainder, with remainder < divisor.

Test Plan:
1. WIDTH=8; start 1 cycle with dividend=100, divisor=7 -> busy high 8 cycles; done pulses one cycle 8 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
2. dividend=255/1 -> quotient=255, remainder=0. dividend=5/9 -> quotient=0, remainder=5. dividend=0/3 -> quotient=0, remainder=0, still 8-cycle latency.
3. dividend=77, divisor=0 -> done one cycle after accept; quotient=8'hFF, remainder=77, div_by_zero=1. A following 9/3 clears div_by_zero and gives quotient=3, remainder=0.
4. Launch 200/13. Assert start with 50/5 on cycle 3 of RUN -> ignored; result quotient=15, remainder=5, done at the original cycle. Then start in the DONE cycle with 50/5 -> accepted; quotient=10, remainder=0 eight cycles later.
5. Launch 123/4; drop rst_n for part of a cycle mid-RUN -> all outputs 0 immediately, no done pulse. After release, 123/4 -> quotient=30, remainder=3.
6. Random sweep of 1000 operand pairs (divisor!=0) -> quotient/remainder match a reference model; the invariant holds; done occurs exactly once per accepted start.

Source files
------------

// File: rtl/serial_divider.sv
// Sequential restoring divider: unsigned dividend / divisor, one quotient bit
// per clock, MSB first. Start-pulse launch with busy/done handshake and
// divide-by-zero reporting. Results are registered and held until the next
// completion.
module serial_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dividend_sr;  // remaining dividend bits, consumed MSB first
  logic [WIDTH-1:0] divisor_r;    // divisor captured at accept
  logic [WIDTH-1:0] quot_work;    // quotient bits collected so far
  logic [WIDTH:0]   pr;           // partial remainder, one guard bit
  logic [CW-1:0]    cnt;          // iterations still to perform

  logic [WIDTH:0]   pr_next;
  logic             qbit;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, trial-subtract the divisor, keep the difference only when it
  // did not go negative. Returns {quotient_bit, next_partial_remainder}.
  function automatic logic [WIDTH+1:0] restore_step(
    input logic [WIDTH:0]   pr_in,
    input logic             next_bit,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {pr_in[WIDTH-1:0], next_bit};
    trial   = shifted - {1'b0, dvs};
    if (!trial[WIDTH]) begin
      restore_step = {1'b1, trial};
    end else begin
      restore_step = {1'b0, shifted};
    end
  endfunction

  // Datapath for the current iteration, evaluated from the working registers
  always_comb begin
    {qbit, pr_next} = restore_step(pr, dividend_sr[WIDTH-1], divisor_r);
  end

  // Control FSM with registered outputs and the iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dividend_sr <= '0;
      divisor_r   <= '0;
      quot_work   <= '0;
      pr          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          // Start requests are ignored here; the divide in flight runs on.
          pr          <= pr_next;
          dividend_sr <= {dividend_sr[WIDTH-2:0], 1'b0};
          quot_work   <= {quot_work[WIDTH-2:0], qbit};
          cnt         <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient    <= {quot_work[WIDTH-2:0], qbit};
            remainder   <= pr_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new launch; DONE lasts one cycle.
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              dividend_sr <= dividend;
              divisor_r   <= divisor;
              quot_work   <= '0;
              pr          <= '0;
              cnt         <= CW'(WIDTH);
              busy        <= 1'b1;
              state       <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: a cycle-level behavioural model
// built from plain '/' and '%' is compared against the DUT on every cycle,
// with directed scenarios pinning literal results and a randomized sweep.
module tb_serial_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int launches = 0;
  int dut_dones = 0;

  serial_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: an accepted divide yields a/b and a%b exactly W
  // cycles later; divide by zero answers on the next cycle.
  int           m_left;
  logic         m_done;
  logic         m_dbz;
  logic [W-1:0] m_q, m_r, p_q, p_r, m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      p_q    <= '0;
      p_r    <= '0;
      m_a    <= '0;
      m_b    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_dbz  <= 1'b0;
        end
      end else if (start) begin
        m_a <= dividend;
        m_b <= divisor;
        if (divisor == 0) begin
          m_done <= 1'b1;
          m_q    <= {W{1'b1}};
          m_r    <= dividend;
          m_dbz  <= 1'b1;
        end else begin
          m_left <= W;
          p_q    <= dividend / divisor;
          p_r    <= dividend % divisor;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(m_left != 0));
      chk("done", int'(done), int'(m_done));
      chk("quotient", int'(quotient), int'(m_q));
      chk("remainder", int'(remainder), int'(m_r));
      chk("div_by_zero", int'(div_by_zero), int'(m_dbz));
      if (done) begin
        dut_dones++;
        if (!div_by_zero) begin
          chk("invariant", int'(quotient) * int'(m_b) + int'(remainder), int'(m_a));
          chk("rem_lt_div", int'(remainder < m_b), 1);
        end
      end
    end
  end

  // Drive start for one edge from the current time; records the accept cycle
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    start    = 1'b0;
    launches++;
  endtask

  // Wait (bounded) for done, then check latency and the literal result
  task automatic wait_done(input int exp_lat, input int eq, input int er, input int edz);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("latency", cyc - acc_cyc, exp_lat);
      chk("q_lit", int'(quotient), eq);
      chk("r_lit", int'(remainder), er);
      chk("dbz_lit", int'(div_by_zero), edz);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;

    // Basic divide and latency
    @(posedge clk); #1;
    launch(8'd100, 8'd7);
    chk("busy_after_accept", int'(busy), 1);
    wait_done(W, 14, 2, 0);

    // Operand corners
    @(posedge clk); #1; launch(8'd255, 8'd1); wait_done(W, 255, 0, 0);
    @(posedge clk); #1; launch(8'd5, 8'd9);   wait_done(W, 0, 5, 0);
    @(posedge clk); #1; launch(8'd0, 8'd3);   wait_done(W, 0, 0, 0);

    // Divide by zero, then a normal divide clears the flag
    @(posedge clk); #1; launch(8'd77, 8'd0);  wait_done(0, 255, 77, 1);
    @(posedge clk); #1;
    chk("dbz_held", int'(div_by_zero), 1);
    chk("q_held", int'(quotient), 255);
    launch(8'd9, 8'd3);
    wait_done(W, 3, 0, 0);

    // Start during RUN is ignored; start in DONE is accepted back-to-back
    @(posedge clk); #1;
    launch(8'd200, 8'd13);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(W, 15, 5, 0);
    launch(8'd50, 8'd5);
    wait_done(W, 10, 0, 0);

    // Asynchronous reset mid-run aborts with no done
    @(posedge clk); #1;
    launch(8'd123, 8'd4);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    launch(8'd123, 8'd4);
    wait_done(W, 30, 3, 0);

    // Randomized sweep
    for (int n = 0; n < 1000; n++) begin
      int gap;
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(1, 255));
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      launch(a, b);
      if ($urandom_range(0, 9) == 0) begin
        start = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(W, int'(a) / int'(b), int'(a) % int'(b), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", dut_dones, launches - 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
